// File: rtl/nbcac_ftf_monitor_if.sv
// nbcac_ftf_monitor_if: codeword bus and monitor status signals between encoder-side driver and checker
interface nbcac_ftf_monitor_if #(
   parameter int W     = 20,
   parameter int CNT_W = 16
);
   logic [W:1]       codein;
   logic             valid_in;
   logic             clear;
   logic             err_now;
   logic             err_sticky;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] word_count;
   logic [4:0]       first_pair;
   logic             halted;
   modport master (
      output codein, valid_in, clear,
      input  err_now, err_sticky, err_count, word_count, first_pair, halted
   );
   modport slave (
      input  codein, valid_in, clear,
      output err_now, err_sticky, err_count, word_count, first_pair, halted
   );
endinterface

// File: rtl/nbcac_ftf_monitor.sv
// nbcac_ftf_monitor: flags opposite-direction toggles on adjacent wires between consecutive accepted codewords
module nbcac_ftf_monitor #(
   parameter int W           = 20,
   parameter int CNT_W       = 16,
   parameter bit HALT_ON_ERR = 1'b0
) (
   input logic                clock,
   input logic                rst_n,
   nbcac_ftf_monitor_if.slave mon
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t           state_q;
   logic [W:1]       prev_q;
   logic             err_now_q, err_sticky_q;
   logic [CNT_W-1:0] err_count_q, word_count_q, err_count_d, word_count_d;
   logic [4:0]       first_pair_q, first_pair_d;
   logic [W-1:1]     pair_v;
   always_comb begin
      pair_v = '0;
      for (int i = 1; i < W; i++)
         pair_v[i] = (prev_q[i] ^ mon.codein[i]) & (prev_q[i+1] ^ mon.codein[i+1]) & (mon.codein[i] ^ mon.codein[i+1]);
      first_pair_d = '0;
      for (int i = W - 1; i >= 1; i--)
         if (pair_v[i]) first_pair_d = 5'(i);
      err_count_d  = &err_count_q ? err_count_q : err_count_q + 1'b1;
      word_count_d = &word_count_q ? word_count_q : word_count_q + 1'b1;
   end
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         err_now_q    <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
         word_count_q <= '0;
         first_pair_q <= '0;
      end else if (mon.clear) begin
         state_q      <= IDLE;
         err_now_q    <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
         word_count_q <= '0;
         first_pair_q <= '0;
      end else begin
         err_now_q <= 1'b0;
         case (state_q)
            IDLE: if (mon.valid_in) begin
               prev_q  <= mon.codein;
               state_q <= RUN;
            end
            RUN: if (mon.valid_in) begin
               prev_q       <= mon.codein;
               word_count_q <= word_count_d;
               if (|pair_v) begin
                  err_now_q    <= 1'b1;
                  err_sticky_q <= 1'b1;
                  err_count_q  <= err_count_d;
                  if (first_pair_q == '0) first_pair_q <= first_pair_d;
                  if (HALT_ON_ERR) state_q <= HALT;
               end
            end
            default: ;
         endcase
      end
   end
   assign mon.err_now    = err_now_q;
   assign mon.err_sticky = err_sticky_q;
   assign mon.err_count  = err_count_q;
   assign mon.word_count = word_count_q;
   assign mon.first_pair = first_pair_q;
   assign mon.halted     = (state_q == HALT);
endmodule

// File: tb/tb_nbcac_ftf_monitor.sv
// tb_nbcac_ftf_monitor: three monitor variants driven in lockstep and checked against a toggle-set model
module tb_nbcac_ftf_monitor;
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   nbcac_ftf_monitor_if #(.W(20), .CNT_W(16)) b0 ();
   nbcac_ftf_monitor_if #(.W(20), .CNT_W(16)) b1 ();
   nbcac_ftf_monitor_if #(.W(20), .CNT_W(4))  b2 ();
   nbcac_ftf_monitor #(.W(20), .CNT_W(16), .HALT_ON_ERR(1'b0)) u0 (.clock(clock), .rst_n(rst_n), .mon(b0.slave));
   nbcac_ftf_monitor #(.W(20), .CNT_W(16), .HALT_ON_ERR(1'b1)) u1 (.clock(clock), .rst_n(rst_n), .mon(b1.slave));
   nbcac_ftf_monitor #(.W(20), .CNT_W(4),  .HALT_ON_ERR(1'b0)) u2 (.clock(clock), .rst_n(rst_n), .mon(b2.slave));

   typedef struct {
      bit          ref_ok;
      logic [19:0] prev;
      int          ec, wc, fp;
      bit          now, sticky, halted;
   } mdl_t;
   mdl_t m[3];
   int   cmax[3] = '{65535, 65535, 15};
   bit   hp[3]   = '{1'b0, 1'b1, 1'b0};
   int   passes = 0, checks = 0, fails = 0;
   logic [19:0] lastc = '0;

   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s[%0d] got %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic chk_inst(int k, logic now, logic st, logic [15:0] ec, logic [15:0] wc, logic [4:0] fp, logic h);
      chk("err_now", k, 32'(now), 32'(m[k].now));
      chk("err_sticky", k, 32'(st), 32'(m[k].sticky));
      chk("err_count", k, 32'(ec), 32'(m[k].ec));
      chk("word_count", k, 32'(wc), 32'(m[k].wc));
      chk("first_pair", k, 32'(fp), 32'(m[k].fp));
      chk("halted", k, 32'(h), 32'(m[k].halted));
   endtask

   task automatic chk_all();
      chk_inst(0, b0.err_now, b0.err_sticky, b0.err_count, b0.word_count, b0.first_pair, b0.halted);
      chk_inst(1, b1.err_now, b1.err_sticky, b1.err_count, b1.word_count, b1.first_pair, b1.halted);
      chk_inst(2, b2.err_now, b2.err_sticky, 16'(b2.err_count), 16'(b2.word_count), b2.first_pair, b2.halted);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m[k] = '{1'b0, 20'h0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_edge(int k, logic [19:0] c, bit v, bit clr);
      logic [19:0] rise, fall, opp;
      if (clr) begin
         m[k].ref_ok = 0; m[k].now = 0; m[k].sticky = 0;
         m[k].ec = 0; m[k].wc = 0; m[k].fp = 0; m[k].halted = 0;
      end else if (m[k].halted || !v) m[k].now = 0;
      else if (!m[k].ref_ok) begin
         m[k].prev = c; m[k].ref_ok = 1; m[k].now = 0;
      end else begin
         rise = c & ~m[k].prev;
         fall = m[k].prev & ~c;
         opp  = (rise & (fall >> 1)) | (fall & (rise >> 1));
         m[k].wc  = (m[k].wc < cmax[k]) ? m[k].wc + 1 : m[k].wc;
         m[k].now = |opp;
         if (m[k].now) begin
            m[k].sticky = 1;
            m[k].ec = (m[k].ec < cmax[k]) ? m[k].ec + 1 : m[k].ec;
            for (int j = 0; j < 19; j++) if (opp[j] && m[k].fp == 0) m[k].fp = j + 1;
            m[k].halted = hp[k];
         end
         m[k].prev = c;
      end
   endtask

   task automatic step(logic [19:0] c, bit v, bit clr);
      b0.codein = c; b1.codein = c; b2.codein = c;
      b0.valid_in = v; b1.valid_in = v; b2.valid_in = v;
      b0.clear = clr; b1.clear = clr; b2.clear = clr;
      if (v) lastc = c;
      @(posedge clock);
      for (int k = 0; k < 3; k++) model_edge(k, c, v, clr);
      #1 chk_all();
   endtask

   initial begin
      model_reset();
      b0.codein = '0; b1.codein = '0; b2.codein = '0;
      b0.valid_in = 0; b1.valid_in = 0; b2.valid_in = 0;
      b0.clear = 0; b1.clear = 0; b2.clear = 0;
      #12 chk_all();
      rst_n = 1'b1;
      step(20'h00000, 1, 0); step(20'h00001, 1, 0); step(20'h00003, 1, 0);
      step(20'h0, 0, 1);
      step(20'h00001, 1, 0); step(20'h00002, 1, 0); step(20'h00002, 0, 0);
      step(20'h0, 0, 1);
      step(20'h00000, 1, 0); step(20'hAAAAA, 1, 0); step(20'h55555, 1, 0);
      step(20'h55595, 1, 0);
      for (int n = 0; n < 5; n++) step(20'($urandom), 1, 0);
      step(20'h00002, 1, 1);
      step(20'h00001, 1, 0); step(20'h00002, 1, 0);
      step(20'h0, 0, 1);
      for (int n = 0; n < 21; n++) step((n % 2) ? 20'h00002 : 20'h00001, 1, 0);
      step(20'h0, 0, 1);
      for (int n = 0; n < 300; n++)
         step($urandom_range(0, 1) ? 20'($urandom) : lastc ^ 20'($urandom_range(0, 3) << $urandom_range(0, 18)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk_all();
      #2 rst_n = 1'b1;
      step(20'h00002, 1, 0);
      step(20'h00001, 1, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
